// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: shares WE3/A3/WD3 between in-order writeback and a
// buffered long-latency result stream, and keeps the pending-destination scoreboard.
module rf_write_arbiter #(
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_we,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_wd,
    output logic        wb_stall,
    input  logic        lu_issue,
    input  logic [4:0]  lu_issue_rd,
    input  logic        lu_valid,
    input  logic [4:0]  lu_rd,
    input  logic [31:0] lu_wd,
    output logic        lu_ready,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        rs1_busy,
    output logic        rs2_busy,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic [31:0] pending,
    output logic        waw_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE     = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [SW-1:0] STARVE_ONE  = SW'(1);

    logic [4:0]    r_fifo_rd [FIFO_DEPTH];
    logic [31:0]   r_fifo_wd [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [SW-1:0] r_starve;
    logic          r_stall;
    logic          r_rf_we;
    logic [4:0]    r_rf_a3;
    logic [31:0]   r_rf_wd;
    logic [31:0]   r_pending;
    logic          r_waw_err;

    logic          w_empty;
    logic          w_full;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_wd;
    logic          w_wb_win;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic [31:0]   w_clr_vec;
    logic [31:0]   w_set_vec;
    logic [31:0]   w_pending_nxt;
    logic          w_err_now;
    logic [AW:0]   w_count_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == FULL_CNT);
    assign w_head_rd = r_fifo_rd[r_rptr];
    assign w_head_wd = r_fifo_wd[r_rptr];

    // A stalled cycle blocks writeback, so the pop condition reduces to "FIFO has data and WB lost".
    assign w_wb_win = wb_we && (wb_rd != 5'd0) && !r_stall;
    assign w_pop    = !w_empty && !w_wb_win;
    assign w_push   = lu_valid && !w_full && (lu_rd != 5'd0);
    assign w_issue  = lu_issue && (lu_issue_rd != 5'd0);

    assign w_clr_vec     = w_pop ? (32'd1 << w_head_rd) : 32'd0;
    assign w_set_vec     = w_issue ? (32'd1 << lu_issue_rd) : 32'd0;
    assign w_pending_nxt = ((r_pending & ~w_clr_vec) | w_set_vec) & ~32'd1;

    assign w_err_now = (w_issue && r_pending[lu_issue_rd] && !w_clr_vec[lu_issue_rd])
                    || (w_wb_win && r_pending[wb_rd])
                    || (w_push && !r_pending[lu_rd]);

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_ONE;
            2'b01:   w_count_nxt = r_count - CNT_ONE;
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_rd[r_wptr] <= lu_rd;
            r_fifo_wd[r_wptr] <= lu_wd;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_stall   <= 1'b0;
            r_rf_we   <= 1'b0;
            r_rf_a3   <= 5'd0;
            r_rf_wd   <= 32'd0;
            r_pending <= 32'd0;
            r_waw_err <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PTR_ONE;
            if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            r_count   <= w_count_nxt;
            r_pending <= w_pending_nxt;
            if (w_err_now) r_waw_err <= 1'b1;

            if (w_wb_win) begin
                r_rf_we <= 1'b1;
                r_rf_a3 <= wb_rd;
                r_rf_wd <= wb_wd;
            end else if (w_pop) begin
                r_rf_we <= 1'b1;
                r_rf_a3 <= w_head_rd;
                r_rf_wd <= w_head_wd;
            end else begin
                r_rf_we <= 1'b0;
            end

            // Head lost to writeback again after STARVE_MAX-1 losses: force one stalled cycle.
            if (w_empty || w_pop) begin
                r_starve <= '0;
                r_stall  <= 1'b0;
            end else if (r_starve == STARVE_LAST) begin
                r_starve <= '0;
                r_stall  <= 1'b1;
            end else begin
                r_starve <= r_starve + STARVE_ONE;
                r_stall  <= 1'b0;
            end
        end
    end

    assign wb_stall = r_stall;
    assign lu_ready = !w_full;
    assign rs1_busy = r_pending[rs1] && (rs1 != 5'd0);
    assign rs2_busy = r_pending[rs2] && (rs2 != 5'd0);
    assign rf_we    = r_rf_we;
    assign rf_a3    = r_rf_a3;
    assign rf_wd    = r_rf_wd;
    assign pending  = r_pending;
    assign waw_err  = r_waw_err;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed scenarios plus a randomized run against a queue-based model.
`timescale 1ns/1ps
module tb_rf_write_arbiter;
    localparam int FIFO_DEPTH = 2;
    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_wd;
    logic        wb_stall;
    logic        lu_issue;
    logic [4:0]  lu_issue_rd;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_wd;
    logic        lu_ready;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;
    logic [31:0] pending;
    logic        waw_err;

    int errors = 0;
    int checks = 0;

    rf_write_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_wd(wb_wd), .wb_stall(wb_stall),
        .lu_issue(lu_issue), .lu_issue_rd(lu_issue_rd),
        .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_wd(lu_wd), .lu_ready(lu_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .rf_we(rf_we), .rf_a3(rf_a3), .rf_wd(rf_wd),
        .pending(pending), .waw_err(waw_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required the bench to finish earlier");
        $fatal(1, "watchdog");
    end

    // Reference model state: result buffer as a queue, scoreboard as a plain bit set.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pend;
    int          m_starve;
    bit          m_stall;
    bit          m_we;
    logic [4:0]  m_a3;
    logic [31:0] m_wd;
    bit          m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 0; wb_rd = 0; wb_wd = 0;
        lu_issue = 0; lu_issue_rd = 0;
        lu_valid = 0; lu_rd = 0; lu_wd = 0;
        rs1 = 0; rs2 = 0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 0;
        idle();
        @(negedge clk);
        rst = 1;
        tick();
    endtask

    task automatic model_reset();
        mq.delete();
        m_pend = 0; m_starve = 0; m_stall = 0;
        m_we = 0; m_a3 = 0; m_wd = 0; m_err = 0;
    endtask

    // Advance the model by one clock edge using the inputs that were present at that edge.
    task automatic model_step(output bit hs);
        bit   wbw;
        bit   pop;
        bit   acc;
        int   n;
        ent_t h;
        n   = mq.size();
        wbw = wb_we && (wb_rd != 0) && !m_stall;
        pop = (n > 0) && !wbw;
        hs  = lu_valid && (n < FIFO_DEPTH);
        acc = hs && (lu_rd != 0);
        if (lu_issue && lu_issue_rd != 0 && m_pend[lu_issue_rd] && !(pop && mq[0].rd == lu_issue_rd)) m_err = 1;
        if (wbw && m_pend[wb_rd]) m_err = 1;
        if (acc && !m_pend[lu_rd]) m_err = 1;
        if (wbw) begin
            m_we = 1; m_a3 = wb_rd; m_wd = wb_wd;
        end else if (pop) begin
            h = mq.pop_front();
            m_we = 1; m_a3 = h.rd; m_wd = h.wd;
            m_pend[h.rd] = 0;
        end else begin
            m_we = 0;
        end
        if (lu_issue && lu_issue_rd != 0) m_pend[lu_issue_rd] = 1;
        if (acc) begin
            h.rd = lu_rd; h.wd = lu_wd;
            mq.push_back(h);
        end
        if (n == 0 || pop) begin
            m_starve = 0; m_stall = 0;
        end else if (m_starve == STARVE_MAX - 1) begin
            m_starve = 0; m_stall = 1;
        end else begin
            m_starve++; m_stall = 0;
        end
    endtask

    task automatic test_reset();
        #2 rst = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL por_rf_we: got %0b want 0", rf_we); end
        checks++; if (rf_a3 !== 5'd0) begin errors++; $display("FAIL por_rf_a3: got %0d want 0", rf_a3); end
        checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL por_rf_wd: got %h want 0", rf_wd); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL por_wb_stall: got %0b want 0", wb_stall); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL por_pending: got %h want 0", pending); end
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL por_waw_err: got %0b want 0", waw_err); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL por_lu_ready: got %0b want 1", lu_ready); end
        @(negedge clk);
        rst = 1;
        tick();
        // Build two buffered entries with pending = {2,1} while WB holds the port.
        lu_issue = 1; lu_issue_rd = 1; tick();
        lu_issue_rd = 2; tick();
        lu_issue = 0;
        wb_we = 1; wb_rd = 10; wb_wd = 32'hA5A5_0001;
        lu_valid = 1; lu_rd = 1; lu_wd = 32'h1111_1111; tick();
        lu_rd = 2; lu_wd = 32'h2222_2222; tick();
        lu_valid = 0;
        #1;
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL pre_rst_lu_ready: got %0b want 0", lu_ready); end
        checks++; if (pending !== 32'h0000_0006) begin errors++; $display("FAIL pre_rst_pending: got %h want 00000006", pending); end
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL pre_rst_rf_we: got %0b want 1", rf_we); end
        #2 rst = 0;
        #1;
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL mid_rst_rf_we: got %0b want 0", rf_we); end
        checks++; if (rf_a3 !== 5'd0) begin errors++; $display("FAIL mid_rst_rf_a3: got %0d want 0", rf_a3); end
        checks++; if (rf_wd !== 32'd0) begin errors++; $display("FAIL mid_rst_rf_wd: got %h want 0", rf_wd); end
        checks++; if (pending !== 32'd0) begin errors++; $display("FAIL mid_rst_pending: got %h want 0", pending); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL mid_rst_wb_stall: got %0b want 0", wb_stall); end
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL mid_rst_waw_err: got %0b want 0", waw_err); end
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_lu_ready: got %0b want 1", lu_ready); end
        idle();
        @(negedge clk);
        rst = 1;
        tick();
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL post_rst_drained: rf_we got %0b want 0", rf_we); end
    endtask

    task automatic test_wb_only();
        idle();
        wb_we = 1; wb_rd = 5; wb_wd = 32'hDEAD_BEEF; tick();
        checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL wb_rf_we: got %0b want 1", rf_we); end
        checks++; if (rf_a3 !== 5'd5) begin errors++; $display("FAIL wb_rf_a3: got %0d want 5", rf_a3); end
        checks++; if (rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wb_rf_wd: got %h want deadbeef", rf_wd); end
        wb_rd = 0; wb_wd = 32'h0000_FFFF; tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL wb_x0_rf_we: got %0b want 0", rf_we); end
        idle(); tick();
    endtask

    task automatic test_lu_roundtrip();
        idle();
        rs1 = 7; lu_issue = 1; lu_issue_rd = 7; tick();
        lu_issue = 0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL lu_busy_c%0d: got %0b want 1", c, rs1_busy); end
            if (c == 4) begin
                checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL lu_no_bypass: rf_we got %0b want 0", rf_we); end
            end
            lu_valid = (c == 3); lu_rd = 7; lu_wd = 32'h1234_5678;
            tick();
        end
        checks++; if (rf_we !== 1'b1 || rf_a3 !== 5'd7) begin errors++; $display("FAIL lu_rf_write: got we=%0b a3=%0d want we=1 a3=7", rf_we, rf_a3); end
        checks++; if (rf_wd !== 32'h1234_5678) begin errors++; $display("FAIL lu_rf_wd: got %h want 12345678", rf_wd); end
        checks++; if (rs1_busy !== 1'b0 || pending[7] !== 1'b0) begin errors++; $display("FAIL lu_clear: busy=%0b pending7=%0b want 0 0", rs1_busy, pending[7]); end
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL lu_no_err: got %0b want 0", waw_err); end
        idle(); tick();
    endtask

    task automatic test_contention();
        idle();
        lu_issue = 1; lu_issue_rd = 12; tick();
        lu_issue = 0;
        lu_valid = 1; lu_rd = 12; lu_wd = 32'hC0FF_EE01;
        wb_we = 1; wb_rd = 13; wb_wd = 32'h1300_0000; tick();
        lu_valid = 0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_wait%0d_stall: got %0b want 0", i, wb_stall); end
            checks++; if (rf_a3 !== 5'd13) begin errors++; $display("FAIL starve_wait%0d_a3: got %0d want 13", i, rf_a3); end
            wb_wd = 32'h1300_0001 + 32'(i);
            tick();
        end
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %0b want 1", wb_stall); end
        tick();
        checks++; if (rf_a3 !== 5'd12 || rf_wd !== 32'hC0FF_EE01) begin errors++; $display("FAIL starve_pop: got a3=%0d wd=%h want 12 c0ffee01", rf_a3, rf_wd); end
        checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL starve_one_cycle: got %0b want 0", wb_stall); end
        checks++; if (pending[12] !== 1'b0) begin errors++; $display("FAIL starve_clear: got %0b want 0", pending[12]); end
        tick();
        checks++; if (rf_a3 !== 5'd13 || rf_wd !== 32'h1300_0004) begin errors++; $display("FAIL starve_held_wb: got a3=%0d wd=%h want 13 13000004", rf_a3, rf_wd); end
        idle(); tick();
    endtask

    task automatic test_full_fifo();
        idle();
        lu_issue = 1; lu_issue_rd = 4; tick();
        lu_issue_rd = 5; tick();
        lu_issue_rd = 6; tick();
        lu_issue = 0;
        wb_we = 1; wb_rd = 11; wb_wd = 32'hB0B0_0000;
        lu_valid = 1; lu_rd = 4; lu_wd = 32'h0000_4444; tick();
        lu_rd = 5; lu_wd = 32'h0000_5555; tick();
        lu_rd = 6; lu_wd = 32'h0000_6666;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_ready%0d: got %0b want 0", i, lu_ready); end
            checks++; if (wb_stall !== 1'b0) begin errors++; $display("FAIL full_stall%0d: got %0b want 0", i, wb_stall); end
            tick();
        end
        #1;
        checks++; if (wb_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b want 1", wb_stall); end
        checks++; if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_pop_ready: got %0b want 0", lu_ready); end
        tick();
        checks++; if (rf_a3 !== 5'd4 || rf_wd !== 32'h0000_4444) begin errors++; $display("FAIL full_pop_head: got a3=%0d wd=%h want 4 00004444", rf_a3, rf_wd); end
        #1;
        checks++; if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %0b want 1", lu_ready); end
        tick();
        lu_valid = 0;
        checks++; if (rf_a3 !== 5'd11 || rf_wd !== 32'hB0B0_0000) begin errors++; $display("FAIL full_held_wb: got a3=%0d wd=%h want 11 b0b00000", rf_a3, rf_wd); end
        idle(); tick();
        checks++; if (rf_a3 !== 5'd5 || rf_wd !== 32'h0000_5555) begin errors++; $display("FAIL full_drain5: got a3=%0d wd=%h want 5 00005555", rf_a3, rf_wd); end
        tick();
        checks++; if (rf_a3 !== 5'd6 || rf_wd !== 32'h0000_6666) begin errors++; $display("FAIL full_drain6: got a3=%0d wd=%h want 6 00006666", rf_a3, rf_wd); end
        tick();
        checks++; if (pending !== 32'd0 || waw_err !== 1'b0) begin errors++; $display("FAIL full_final: pending=%h err=%0b want 0 0", pending, waw_err); end
    endtask

    task automatic test_errors();
        apply_reset();
        lu_issue = 1; lu_issue_rd = 3; tick();
        tick();
        lu_issue = 0;
        checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL err_double_issue: got %0b want 1", waw_err); end
        repeat (5) tick();
        checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b want 1", waw_err); end
        apply_reset();
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL err_reset_clears: got %0b want 0", waw_err); end
        lu_issue = 1; lu_issue_rd = 9; tick();
        lu_issue = 0;
        wb_we = 1; wb_rd = 9; wb_wd = 32'h0000_0009; tick();
        wb_we = 0;
        checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL err_wb_pending: got %0b want 1", waw_err); end
        apply_reset();
        lu_valid = 1; lu_rd = 20; lu_wd = 32'h0000_0020; tick();
        lu_valid = 0;
        checks++; if (waw_err !== 1'b1) begin errors++; $display("FAIL err_push_unpending: got %0b want 1", waw_err); end
        apply_reset();
        lu_valid = 1; lu_rd = 0; lu_wd = 32'h0000_0BAD; tick();
        lu_valid = 0;
        checks++; if (waw_err !== 1'b0) begin errors++; $display("FAIL err_x0_discard: got %0b want 0", waw_err); end
        tick();
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL x0_not_written: rf_we got %0b want 0", rf_we); end
        apply_reset();
    endtask

    task automatic test_random();
        logic [4:0] iss[$];
        bit hs;
        bit hold;
        hold = 0;
        apply_reset();
        model_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!hold) begin
                lu_valid = 0;
                if (iss.size() > 0 && $urandom_range(0, 1) == 1) begin
                    lu_valid = 1; lu_rd = iss[0]; lu_wd = $urandom;
                end else if ($urandom_range(0, 15) == 0) begin
                    lu_valid = 1; lu_rd = 0; lu_wd = $urandom;
                end
            end
            wb_we = ($urandom_range(0, 3) != 0);
            wb_rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
            wb_wd = $urandom;
            lu_issue = 0;
            if (iss.size() < 4 && $urandom_range(0, 2) == 0) begin
                lu_issue = 1; lu_issue_rd = 5'($urandom_range(1, 15));
            end
            rs1 = 5'($urandom_range(0, 31));
            rs2 = 5'($urandom_range(0, 15));
            #1;
            checks++; if (lu_ready !== (mq.size() < FIFO_DEPTH)) begin errors++; $display("FAIL rnd%0d_lu_ready: got %0b want %0b", cyc, lu_ready, mq.size() < FIFO_DEPTH); end
            checks++; if (rs1_busy !== (m_pend[rs1] && rs1 != 0)) begin errors++; $display("FAIL rnd%0d_rs1_busy: got %0b want %0b", cyc, rs1_busy, m_pend[rs1] && rs1 != 0); end
            checks++; if (rs2_busy !== (m_pend[rs2] && rs2 != 0)) begin errors++; $display("FAIL rnd%0d_rs2_busy: got %0b want %0b", cyc, rs2_busy, m_pend[rs2] && rs2 != 0); end
            tick();
            model_step(hs);
            if (lu_valid) begin
                hold = !hs;
                if (hs && lu_rd != 0) void'(iss.pop_front());
            end else begin
                hold = 0;
            end
            if (lu_issue) iss.push_back(lu_issue_rd);
            checks++; if (rf_we !== m_we || rf_a3 !== m_a3 || rf_wd !== m_wd) begin errors++; $display("FAIL rnd%0d_rf: got we=%0b a3=%0d wd=%h want we=%0b a3=%0d wd=%h", cyc, rf_we, rf_a3, rf_wd, m_we, m_a3, m_wd); end
            checks++; if (wb_stall !== m_stall) begin errors++; $display("FAIL rnd%0d_wb_stall: got %0b want %0b", cyc, wb_stall, m_stall); end
            checks++; if (pending !== m_pend) begin errors++; $display("FAIL rnd%0d_pending: got %h want %h", cyc, pending, m_pend); end
            checks++; if (waw_err !== m_err) begin errors++; $display("FAIL rnd%0d_waw_err: got %0b want %0b", cyc, waw_err, m_err); end
        end
        idle();
        tick();
    endtask

    initial begin
        rst = 1;
        idle();
        test_reset();
        test_wb_only();
        test_lu_roundtrip();
        test_contention();
        test_full_fifo();
        test_errors();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
